// File: rtl/gate_sweep_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gate_sweep_pkg
// Purpose  : Shared types and constants for the gate truth-table sweeper.
//            Provides the sweep state encoding, the golden truth table and
//            bit positions of each gate output inside a 5-bit capture.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } sweep_state_t;

  localparam int N_COMB = 4;
  localparam int N_GATE = 5;

  // Packed {na_x, NOR, OR, NAND, AND} per combination; idx 0 in the LSBs.
  localparam logic [19:0] GOLDEN_TABLE = 20'h29ADA;

  localparam int BIT_AND  = 0;
  localparam int BIT_NAND = 1;
  localparam int BIT_OR   = 2;
  localparam int BIT_NOR  = 3;
  localparam int BIT_NA_X = 4;

  function automatic logic [4:0] golden(input logic [1:0] idx);
    logic [19:0] tbl;
    tbl = GOLDEN_TABLE;
    return tbl[int'(idx)*5 +: 5];
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_sweep_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gate_sweep_timer
// Purpose  : Settle down-counter. Reloads to SETTLE-1 on clear or on terminal
//            count; o_tc strobes on the enabled cycle where the count is 0,
//            i.e. once every SETTLE enabled cycles.
// Ports    : clk, reset_n - clock and async active-low reset
//            i_clear      - reload counter (priority over i_en)
//            i_en         - count down this cycle
//            o_tc         - terminal-count strobe (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module gate_sweep_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [3:0] c_LOAD = 4'(SETTLE - 1);

  logic [3:0] r_cnt;

  assign o_tc = i_en && !i_clear && (r_cnt == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= c_LOAD;
    end else if (i_clear) begin
      r_cnt <= c_LOAD;
    end else if (i_en) begin
      if (r_cnt == 4'd0) r_cnt <= c_LOAD;
      else               r_cnt <= r_cnt - 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gates_using_2x1_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gates_using_2x1_mux
// Purpose  : Basic two-input gate library where every gate is a 2:1 mux
//            selected by x, with y / ~y / constants on the data inputs.
// Ports    : x, y            - gate inputs
//            o_and .. o_na_x - AND, NAND, OR, NOR and NOT-x outputs
// Revision : 1.0 - initial release
// ============================================================================
module gates_using_2x1_mux (
  input  logic x,
  input  logic y,
  output logic o_and,
  output logic o_nand,
  output logic o_or,
  output logic o_nor,
  output logic o_na_x
);

  function automatic logic mux2(input logic a, input logic b, input logic s);
    return s ? b : a;
  endfunction

  assign o_and  = mux2(1'b0, y,    x);
  assign o_nand = mux2(1'b1, ~y,   x);
  assign o_or   = mux2(y,    1'b1, x);
  assign o_nor  = mux2(~y,   1'b0, x);
  assign o_na_x = mux2(1'b1, 1'b0, x);

endmodule
`default_nettype wire

// File: rtl/gate_truth_table_sweeper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gate_truth_table_sweeper
// Purpose  : Self-test sequencer for the mux gate block. Walks x/y through
//            the four input combinations, holds each for SETTLE cycles,
//            captures the 5 gate outputs, builds a 20-bit table and compares
//            it with the golden table.
// Ports    : clk, reset_n  - clock, async active-low reset
//            start, abort  - begin sweep (IDLE only) / cancel sweep (DRIVE)
//            x, y          - registered drive to the gate block
//            gate_out      - {na_x, NOR, OR, NAND, AND} from the gate block
//            busy, done    - sweep in progress / one-cycle completion pulse
//            table_out     - captured table, idx at [5*idx +: 5]
//            mismatch      - per-combination compare failure
//            pass          - last completed sweep matched golden
// Revision : 1.0 - initial release
// ============================================================================
module gate_truth_table_sweeper
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int N_OUT  = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  output logic                      x,
  output logic                      y,
  input  logic [N_OUT-1:0]          gate_out,
  output logic                      busy,
  output logic                      done,
  output logic [N_COMB*N_OUT-1:0]   table_out,
  output logic [N_COMB-1:0]         mismatch,
  output logic                      pass
);

  sweep_state_t              r_state;
  sweep_state_t              w_state_next;
  logic [1:0]                r_idx;
  logic [1:0]                w_idx_inc;
  logic                      r_x;
  logic                      r_y;
  logic [N_COMB*N_OUT-1:0]   r_table;
  logic [N_COMB-1:0]         r_mismatch;
  logic [N_COMB-1:0]         w_mismatch_next;
  logic                      r_pass;
  logic                      w_tc;
  logic                      w_timer_clear;
  logic                      w_timer_en;
  logic                      w_capture;
  logic                      w_accept_start;
  logic                      w_do_abort;
  logic                      w_last_comb;

  assign w_accept_start = (r_state == S_IDLE)  && start && !abort;
  assign w_do_abort     = (r_state == S_DRIVE) && abort;
  assign w_timer_en     = (r_state == S_DRIVE) && !abort;
  // Hold the counter at its load value whenever no sweep is running so the
  // first combination always gets a full SETTLE window.
  assign w_timer_clear  = (r_state != S_DRIVE) || abort;
  assign w_capture      = w_timer_en && w_tc;
  assign w_idx_inc      = r_idx + 2'd1;
  assign w_last_comb    = (r_idx == 2'd3);

  gate_sweep_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_timer_clear),
    .i_en    (w_timer_en),
    .o_tc    (w_tc)
  );

  // Mismatch vector including the current capture, so pass can be decided
  // on the same edge that enters DONE.
  always_comb begin
    w_mismatch_next        = r_mismatch;
    w_mismatch_next[r_idx] = (gate_out != golden(r_idx));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept_start) w_state_next = S_DRIVE;
      S_DRIVE: begin
        if (abort)                         w_state_next = S_IDLE;
        else if (w_capture && w_last_comb) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx      <= 2'd0;
      r_x        <= 1'b0;
      r_y        <= 1'b0;
      r_table    <= '0;
      r_mismatch <= '0;
      r_pass     <= 1'b0;
    end else if (w_accept_start) begin
      r_idx      <= 2'd0;
      r_x        <= 1'b0;
      r_y        <= 1'b0;
      r_table    <= '0;
      r_mismatch <= '0;
      r_pass     <= 1'b0;
    end else if (w_do_abort) begin
      // Partial table and mismatch are kept for debug.
      r_idx  <= 2'd0;
      r_x    <= 1'b0;
      r_y    <= 1'b0;
      r_pass <= 1'b0;
    end else if (w_capture) begin
      r_table[int'(r_idx)*N_OUT +: N_OUT] <= gate_out;
      r_mismatch                          <= w_mismatch_next;
      if (w_last_comb) begin
        r_idx  <= 2'd0;
        r_x    <= 1'b0;
        r_y    <= 1'b0;
        r_pass <= (w_mismatch_next == '0);
      end else begin
        r_idx <= w_idx_inc;
        r_x   <= w_idx_inc[1];
        r_y   <= w_idx_inc[0];
      end
    end
  end

  assign x         = r_x;
  assign y         = r_y;
  assign busy      = (r_state == S_DRIVE);
  assign done      = (r_state == S_DONE);
  assign table_out = r_table;
  assign mismatch  = r_mismatch;
  assign pass      = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_gate_truth_table_sweeper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gate_truth_table_sweeper
// Purpose  : Directed self-checking bench for gate_truth_table_sweeper with
//            the mux gate block as partner. Instance A uses SETTLE=2 with a
//            stuck-at mask on the gate outputs; instance B uses SETTLE=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance A (SETTLE=2) ----------------
  logic        rst_n_a, start_a, abort_a;
  logic        x_a, y_a, busy_a, done_a, pass_a;
  logic [4:0]  gates_a, gate_out_a, stuck_mask;
  logic [19:0] table_a;
  logic [3:0]  mm_a;

  gates_using_2x1_mux u_gates_a (
    .x(x_a), .y(y_a),
    .o_and(gates_a[0]), .o_nand(gates_a[1]), .o_or(gates_a[2]),
    .o_nor(gates_a[3]), .o_na_x(gates_a[4])
  );
  assign gate_out_a = gates_a & ~stuck_mask;

  gate_truth_table_sweeper #(.SETTLE(2), .N_OUT(5)) u_dut_a (
    .clk(clk), .reset_n(rst_n_a), .start(start_a), .abort(abort_a),
    .x(x_a), .y(y_a), .gate_out(gate_out_a), .busy(busy_a), .done(done_a),
    .table_out(table_a), .mismatch(mm_a), .pass(pass_a)
  );

  // ---------------- instance B (SETTLE=1) ----------------
  logic        rst_n_b, start_b, abort_b;
  logic        x_b, y_b, busy_b, done_b, pass_b;
  logic [4:0]  gates_b;
  logic [19:0] table_b;
  logic [3:0]  mm_b;

  gates_using_2x1_mux u_gates_b (
    .x(x_b), .y(y_b),
    .o_and(gates_b[0]), .o_nand(gates_b[1]), .o_or(gates_b[2]),
    .o_nor(gates_b[3]), .o_na_x(gates_b[4])
  );

  gate_truth_table_sweeper #(.SETTLE(1), .N_OUT(5)) u_dut_b (
    .clk(clk), .reset_n(rst_n_b), .start(start_b), .abort(abort_b),
    .x(x_b), .y(y_b), .gate_out(gates_b), .busy(busy_b), .done(done_b),
    .table_out(table_b), .mismatch(mm_b), .pass(pass_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if ({busy_a, done_a, x_a, y_a, pass_a} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {busy_a, done_a, x_a, y_a, pass_a});
    end
    n_tests++;
    if (table_a !== 20'h0 || mm_a !== 4'h0) begin
      n_fail++; $display("FAIL reset_table: got %h/%b expected 00000/0000", table_a, mm_a);
    end
    @(negedge clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    step();
    n_tests++;
    if ({busy_a, done_a, busy_b, done_b} !== 4'b0) begin
      n_fail++; $display("FAIL reset_release_idle: got %b expected 0000", {busy_a, done_a, busy_b, done_b});
    end
  endtask

  task automatic test_good_sweep();
    logic [1:0] ei;
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ei = 2'(k / 2);
      n_tests++;
      if ({busy_a, done_a, x_a, y_a} !== {2'b10, ei}) begin
        n_fail++; $display("FAIL good_drive k=%0d: got %b expected %b", k, {busy_a, done_a, x_a, y_a}, {2'b10, ei});
      end
      step();
    end
    n_tests++;
    if ({busy_a, done_a, x_a, y_a} !== 4'b0100) begin
      n_fail++; $display("FAIL good_done: got %b expected 0100", {busy_a, done_a, x_a, y_a});
    end
    n_tests++;
    if (table_a !== 20'h29ADA) begin
      n_fail++; $display("FAIL good_table: got %h expected 29ada", table_a);
    end
    n_tests++;
    if (mm_a !== 4'b0000 || pass_a !== 1'b1) begin
      n_fail++; $display("FAIL good_pass: got mm=%b pass=%b expected mm=0000 pass=1", mm_a, pass_a);
    end
    step();
    n_tests++;
    if ({busy_a, done_a, pass_a} !== 3'b001) begin
      n_fail++; $display("FAIL good_after_done: got %b expected 001", {busy_a, done_a, pass_a});
    end
  endtask

  task automatic test_stuck_and();
    int dones;
    dones = 0;
    stuck_mask = 5'b00001;
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (done_a) dones++;
      step();
    end
    n_tests++;
    if (done_a !== 1'b1 || dones != 0) begin
      n_fail++; $display("FAIL stuck_done: got done=%b early=%0d expected done=1 early=0", done_a, dones);
    end
    n_tests++;
    if (table_a !== 20'h21ADA) begin
      n_fail++; $display("FAIL stuck_table: got %h expected 21ada", table_a);
    end
    n_tests++;
    if (mm_a !== 4'b1000 || pass_a !== 1'b0) begin
      n_fail++; $display("FAIL stuck_mm: got mm=%b pass=%b expected mm=1000 pass=0", mm_a, pass_a);
    end
    step();
    stuck_mask = 5'b00000;
  endtask

  task automatic test_start_ignored();
    int dones;
    logic [1:0] ei;
    dones = 0;
    start_a = 1'b1; step();
    for (int k = 0; k < 12; k++) begin
      start_a = (k == 2 || k == 4);
      if (k < 8) begin
        ei = 2'(k / 2);
        n_tests++;
        if ({busy_a, x_a, y_a} !== {1'b1, ei}) begin
          n_fail++; $display("FAIL restart_seq k=%0d: got %b expected %b", k, {busy_a, x_a, y_a}, {1'b1, ei});
        end
      end
      if (done_a) begin
        dones++;
        n_tests++;
        if (k != 8) begin
          n_fail++; $display("FAIL restart_done_cycle: got %0d expected 8", k);
        end
      end
      step();
    end
    start_a = 1'b0;
    n_tests++;
    if (dones != 1 || table_a !== 20'h29ADA) begin
      n_fail++; $display("FAIL restart_single_done: got %0d/%h expected 1/29ada", dones, table_a);
    end
  endtask

  task automatic test_abort();
    int dones;
    dones = 0;
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int k = 0; k < 4; k++) step();
    n_tests++;
    if ({busy_a, x_a, y_a} !== 3'b110) begin
      n_fail++; $display("FAIL abort_at_idx2: got %b expected 110", {busy_a, x_a, y_a});
    end
    abort_a = 1'b1; step(); abort_a = 1'b0;
    n_tests++;
    if ({busy_a, done_a, x_a, y_a, pass_a} !== 5'b0) begin
      n_fail++; $display("FAIL abort_idle: got %b expected 00000", {busy_a, done_a, x_a, y_a, pass_a});
    end
    n_tests++;
    if (table_a !== 20'h002DA || mm_a !== 4'b0000) begin
      n_fail++; $display("FAIL abort_partial: got %h/%b expected 002da/0000", table_a, mm_a);
    end
    for (int k = 0; k < 10; k++) begin
      if (done_a || busy_a) dones++;
      step();
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", dones);
    end
    start_a = 1'b1; abort_a = 1'b1; step(); start_a = 1'b0; abort_a = 1'b0;
    n_tests++;
    if (busy_a !== 1'b0 || table_a !== 20'h002DA) begin
      n_fail++; $display("FAIL abort_wins_start: got busy=%b table=%h expected 0/002da", busy_a, table_a);
    end
  endtask

  task automatic test_async_reset();
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int k = 0; k < 3; k++) step();
    #2;
    rst_n_a = 1'b0;
    #1;
    n_tests++;
    if ({busy_a, done_a, x_a, y_a, pass_a} !== 5'b0 || table_a !== 20'h0 || mm_a !== 4'h0) begin
      n_fail++; $display("FAIL async_reset: got %b %h %b expected 00000 00000 0000", {busy_a, done_a, x_a, y_a, pass_a}, table_a, mm_a);
    end
    @(negedge clk);
    rst_n_a = 1'b1;
    step();
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int k = 0; k < 8; k++) step();
    n_tests++;
    if (done_a !== 1'b1 || table_a !== 20'h29ADA || pass_a !== 1'b1) begin
      n_fail++; $display("FAIL async_resweep: got done=%b table=%h pass=%b expected 1/29ada/1", done_a, table_a, pass_a);
    end
    step();
  endtask

  task automatic test_settle1();
    start_b = 1'b1; step(); start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({busy_b, done_b, x_b, y_b} !== {2'b10, 2'(k)}) begin
        n_fail++; $display("FAIL settle1_drive k=%0d: got %b expected %b", k, {busy_b, done_b, x_b, y_b}, {2'b10, 2'(k)});
      end
      step();
    end
    n_tests++;
    if (done_b !== 1'b1 || busy_b !== 1'b0 || table_b !== 20'h29ADA || pass_b !== 1'b1 || mm_b !== 4'b0) begin
      n_fail++; $display("FAIL settle1_done: got done=%b busy=%b table=%h pass=%b mm=%b expected 1/0/29ada/1/0000", done_b, busy_b, table_b, pass_b, mm_b);
    end
    step();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; stuck_mask = 5'b00000;
    start_b = 1'b0; abort_b = 1'b0;
    test_reset();
    test_good_sweep();
    test_stuck_and();
    test_start_ignored();
    test_abort();
    test_async_reset();
    test_settle1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
